display_scheduler: RTL and testbench

Sequences the hex buffer that feeds the N-digit seven-segment encoder in the digital lock. Arbitrates between two requesters: the persistent entry buffer (digits typed by the user) and timed status messages (e.g. unlock or fail codes). A message has priority, is held for a fixed number of cycles and can optionally blink. The block then falls back to the entry buffer. Outputs are registered and drive the encoder's hex input plus a per-digit blanking mask applied downstream.

---
 rtl/display_scheduler_pkg.sv | 15 +
 rtl/display_scheduler_if.sv | 29 ++
 rtl/display_blink_timer.sv | 39 +++
 rtl/display_scheduler.sv | 108 ++++++++++
 tb/tb_display_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_scheduler_pkg.sv
// Shared types and helpers for the display scheduler.
// Provides the FSM state type and counter width helper.
package display_scheduler_pkg;

  typedef enum logic {
    SHOW_ENTRY = 1'b0,
    SHOW_MSG   = 1'b1
  } state_t;

  // Counter width for a terminal count n, never below one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Entry/message request bus and registered display outputs.
// master: requester side, slave: display_scheduler side.
interface display_scheduler_if #(
  parameter int DISPLAYS = 6
);
  logic [4*DISPLAYS-1:0] entry_hex;
  logic [DISPLAYS-1:0]   entry_mask;
  logic                  entry_valid;
  logic [4*DISPLAYS-1:0] msg_hex;
  logic                  msg_blink;
  logic                  msg_valid;
  logic                  msg_ready;
  logic                  msg_abort;
  logic [4*DISPLAYS-1:0] hex_out;
  logic [DISPLAYS-1:0]   blank_out;
  logic                  msg_done;

  modport master (
    output entry_hex, entry_mask, entry_valid,
    output msg_hex, msg_blink, msg_valid, msg_abort,
    input  msg_ready, hex_out, blank_out, msg_done
  );

  modport slave (
    input  entry_hex, entry_mask, entry_valid,
    input  msg_hex, msg_blink, msg_valid, msg_abort,
    output msg_ready, hex_out, blank_out, msg_done
  );
endinterface

// File: rtl/display_blink_timer.sv
// Reloadable down-counter toggling a dark phase every BLINK_CYCLES.
// Ports: clock, reset, clear (reload, phase visible), enable, dark, dark_nxt.
module display_blink_timer
  import display_scheduler_pkg::*;
#(
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic dark,
  output logic dark_nxt
);

  localparam int BW = cnt_w(BLINK_CYCLES);
  localparam logic [BW-1:0] LOAD = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] cnt;
  logic          wrap;

  assign wrap     = enable && (cnt == '0);
  // Phase after the coming edge, so the owner can register it.
  assign dark_nxt = clear ? 1'b0 : (dark ^ wrap);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dark <= 1'b0;
    end else if (clear) begin
      cnt  <= LOAD;
      dark <= 1'b0;
    end else if (enable) begin
      cnt  <= wrap ? LOAD : cnt - BW'(1);
      dark <= dark_nxt;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates entry buffer vs timed/blinking messages for the hex display.
// Ports: clock, reset (async high), bus (display_scheduler_if.slave).
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int DISPLAYS     = 6,
  parameter int HOLD_CYCLES  = 50000000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic clock,
  input  logic reset,
  display_scheduler_if.slave bus
);

  localparam int HEX_MSB = 4*DISPLAYS - 1;
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  state_t              state;
  logic [HEX_MSB:0]    entry_reg;
  logic [HEX_MSB:0]    entry_nxt;
  logic [DISPLAYS-1:0] mask_reg;
  logic [DISPLAYS-1:0] mask_nxt;
  logic [HW-1:0]       hold_cnt;
  logic                blink_reg;
  logic                accept;
  logic                finish;
  logic                dark;
  logic                dark_nxt;
  logic [HEX_MSB:0]    hex_q;
  logic [DISPLAYS-1:0] blank_q;
  logic                ready_q;
  logic                done_q;

  // Bypass so a capture is visible on the very next cycle.
  assign entry_nxt = bus.entry_valid ? bus.entry_hex : entry_reg;
  assign mask_nxt  = bus.entry_valid ? bus.entry_mask : mask_reg;

  assign accept = (state == SHOW_ENTRY) && bus.msg_valid && ready_q;
  assign finish = (state == SHOW_MSG)
                && (bus.msg_abort || (hold_cnt == '0));

  display_blink_timer #(
    .BLINK_CYCLES(BLINK_CYCLES)
  ) u_blink (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .enable  (state == SHOW_MSG),
    .dark    (dark),
    .dark_nxt(dark_nxt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= SHOW_ENTRY;
      entry_reg <= '0;
      mask_reg  <= '0;
      hold_cnt  <= '0;
      blink_reg <= 1'b0;
      hex_q     <= '0;
      blank_q   <= '1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      entry_reg <= entry_nxt;
      mask_reg  <= mask_nxt;
      done_q    <= 1'b0;
      unique case (state)
        SHOW_ENTRY: begin
          if (accept) begin
            state     <= SHOW_MSG;
            hex_q     <= bus.msg_hex;
            blink_reg <= bus.msg_blink;
            hold_cnt  <= HOLD_LOAD;
            blank_q   <= '0;
            ready_q   <= 1'b0;
          end else begin
            hex_q   <= entry_nxt;
            blank_q <= ~mask_nxt;
            ready_q <= 1'b1;
          end
        end
        SHOW_MSG: begin
          if (finish) begin
            state   <= SHOW_ENTRY;
            hex_q   <= entry_nxt;
            blank_q <= ~mask_nxt;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
            blank_q  <= {DISPLAYS{blink_reg & dark_nxt}};
          end
        end
      endcase
    end
  end

  assign bus.hex_out   = hex_q;
  assign bus.blank_out = blank_q;
  assign bus.msg_ready = ready_q;
  assign bus.msg_done  = done_q;

  logic unused;
  assign unused = dark;

endmodule

// File: tb/tb_display_scheduler.sv
// Randomized self-checking bench for display_scheduler.
// Expected views come from message timing rules computed per cycle index.
module tb_display_scheduler;

  localparam int D = 6;
  localparam int H = 8;
  localparam int B = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [4*D-1:0] em;
  logic [D-1:0]   mm;

  display_scheduler_if #(.DISPLAYS(D)) bus ();

  display_scheduler #(
    .DISPLAYS    (D),
    .HOLD_CYCLES (H),
    .BLINK_CYCLES(B)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [D-1:0] exp_blank(
    input bit blink, input int k);
    if (blink && (((k - 1) / B) % 2 == 1)) return '1;
    return '0;
  endfunction

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (bus.hex_out !== '0) begin
      errors++;
      $display("FAIL rst_hex got %h want 0", bus.hex_out);
    end
    checks++;
    if (bus.blank_out !== '1) begin
      errors++;
      $display("FAIL rst_blank got %b want all1", bus.blank_out);
    end
    checks++;
    if (bus.msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b want 1", bus.msg_ready);
    end
    checks++;
    if (bus.msg_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got %b want 0", bus.msg_done);
    end
    reset = 1'b0;
    em = '0;
    mm = '0;
  endtask

  task automatic test_entry();
    logic [4*D-1:0] h;
    logic [D-1:0]   m;
    for (int i = 0; i < 4; i++) begin
      h = (i == 0) ? 24'h000123 : 24'($urandom);
      m = (i == 0) ? 6'b000111 : 6'($urandom);
      bus.entry_hex   = h;
      bus.entry_mask  = m;
      bus.entry_valid = 1'b1;
      tick();
      bus.entry_valid = 1'b0;
      bus.entry_hex   = 24'($urandom);
      bus.entry_mask  = 6'($urandom);
      em = h;
      mm = m;
      checks++;
      if (bus.hex_out !== em) begin
        errors++;
        $display("FAIL entry_hex got %h want %h", bus.hex_out, em);
      end
      checks++;
      if (bus.blank_out !== ~mm) begin
        errors++;
        $display("FAIL entry_blank got %b want %b",
                 bus.blank_out, ~mm);
      end
      tick();
      checks++;
      if (bus.hex_out !== em) begin
        errors++;
        $display("FAIL entry_hold got %h want %h", bus.hex_out, em);
      end
    end
  endtask

  task automatic test_message();
    logic [4*D-1:0] m;
    logic [4*D-1:0] uh;
    logic [D-1:0]   um;
    bit blink;
    int abort_at;
    int upd_at;
    for (int i = 0; i < 10; i++) begin
      m = 24'($urandom);
      blink = (i == 1) ? 1'b1 : 1'b0;
      abort_at = (i == 3) ? 3 : 0;
      upd_at = (i == 2) ? 3 : 0;
      uh = (i == 2) ? 24'h000456 : 24'($urandom);
      um = (i == 2) ? 6'b000111 : 6'($urandom);
      if (i == 0) m = 24'hAAAAAA;
      if (i >= 4) begin
        blink = 1'($urandom);
        abort_at = $urandom_range(0, H);
        upd_at = $urandom_range(0, H);
      end
      bus.msg_hex   = m;
      bus.msg_blink = blink;
      bus.msg_valid = 1'b1;
      checks++;
      if (bus.msg_ready !== 1'b1) begin
        errors++;
        $display("FAIL pre_ready got %b want 1", bus.msg_ready);
      end
      tick();
      bus.msg_valid = 1'b0;
      bus.msg_hex   = 24'($urandom);
      bus.msg_blink = 1'($urandom);
      for (int k = 1; k <= H; k++) begin
        checks++;
        if (bus.hex_out !== m) begin
          errors++;
          $display("FAIL msg_hex k=%0d got %h want %h",
                   k, bus.hex_out, m);
        end
        checks++;
        if (bus.blank_out !== exp_blank(blink, k)) begin
          errors++;
          $display("FAIL msg_blank k=%0d got %b want %b",
                   k, bus.blank_out, exp_blank(blink, k));
        end
        checks++;
        if (bus.msg_ready !== 1'b0 || bus.msg_done !== 1'b0) begin
          errors++;
          $display("FAIL msg_flags k=%0d got %b%b want 00",
                   k, bus.msg_ready, bus.msg_done);
        end
        if (k == upd_at) begin
          bus.entry_hex   = uh;
          bus.entry_mask  = um;
          bus.entry_valid = 1'b1;
        end
        if (k == abort_at) bus.msg_abort = 1'b1;
        tick();
        bus.entry_valid = 1'b0;
        bus.msg_abort   = 1'b0;
        if (k == upd_at) begin
          em = uh;
          mm = um;
        end
        if (k == abort_at) break;
      end
      checks++;
      if (bus.hex_out !== em || bus.blank_out !== ~mm) begin
        errors++;
        $display("FAIL end_view got %h/%b want %h/%b",
                 bus.hex_out, bus.blank_out, em, ~mm);
      end
      checks++;
      if (bus.msg_done !== 1'b1 || bus.msg_ready !== 1'b1) begin
        errors++;
        $display("FAIL end_flags got %b%b want 11",
                 bus.msg_done, bus.msg_ready);
      end
      tick();
      checks++;
      if (bus.msg_done !== 1'b0 || bus.hex_out !== em) begin
        errors++;
        $display("FAIL post_end got %b/%h want 0/%h",
                 bus.msg_done, bus.hex_out, em);
      end
    end
  endtask

  task automatic test_abort_idle();
    bus.msg_abort = 1'b1;
    tick();
    bus.msg_abort = 1'b0;
    checks++;
    if (bus.msg_done !== 1'b0 || bus.hex_out !== em) begin
      errors++;
      $display("FAIL idle_abort got %b/%h want 0/%h",
               bus.msg_done, bus.hex_out, em);
    end
  endtask

  task automatic test_back_to_back();
    logic [4*D-1:0] m1;
    logic [4*D-1:0] m2;
    m1 = 24'($urandom);
    m2 = 24'($urandom);
    bus.msg_hex   = m1;
    bus.msg_blink = 1'b0;
    bus.msg_valid = 1'b1;
    tick();
    bus.msg_hex = m2;
    for (int k = 1; k <= H; k++) begin
      checks++;
      if (bus.hex_out !== m1) begin
        errors++;
        $display("FAIL b2b_m1 k=%0d got %h want %h",
                 k, bus.hex_out, m1);
      end
      tick();
    end
    checks++;
    if (bus.hex_out !== em || bus.msg_done !== 1'b1
        || bus.msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap got %h/%b%b want %h/11",
               bus.hex_out, bus.msg_done, bus.msg_ready, em);
    end
    tick();
    bus.msg_valid = 1'b0;
    checks++;
    if (bus.hex_out !== m2 || bus.msg_ready !== 1'b0
        || bus.blank_out !== '0) begin
      errors++;
      $display("FAIL b2b_m2 got %h/%b/%b want %h/0/0",
               bus.hex_out, bus.msg_ready, bus.blank_out, m2);
    end
    for (int k = 1; k < H; k++) tick();
    tick();
    checks++;
    if (bus.msg_done !== 1'b1 || bus.hex_out !== em) begin
      errors++;
      $display("FAIL b2b_end got %b/%h want 1/%h",
               bus.msg_done, bus.hex_out, em);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.msg_hex   = 24'($urandom);
    bus.msg_blink = 1'b1;
    bus.msg_valid = 1'b1;
    tick();
    bus.msg_valid = 1'b0;
    tick();
    tick();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.hex_out !== '0 || bus.blank_out !== '1
        || bus.msg_ready !== 1'b1 || bus.msg_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got %h/%b/%b%b want 0/all1/10",
               bus.hex_out, bus.blank_out,
               bus.msg_ready, bus.msg_done);
    end
    em = '0;
    mm = '0;
    tick();
    checks++;
    if (bus.msg_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_done got %b want 0", bus.msg_done);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.hex_out !== '0 || bus.blank_out !== '1
        || bus.msg_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_after got %h/%b/%b want 0/all1/0",
               bus.hex_out, bus.blank_out, bus.msg_done);
    end
  endtask

  initial begin
    bus.entry_hex   = '0;
    bus.entry_mask  = '0;
    bus.entry_valid = 1'b0;
    bus.msg_hex     = '0;
    bus.msg_blink   = 1'b0;
    bus.msg_valid   = 1'b0;
    bus.msg_abort   = 1'b0;
    test_reset();
    test_entry();
    test_message();
    test_abort_idle();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
